coco_kbd_matrix: RTL and testbench

Parametrised successor to the fixed 8x8 PS/2 keyboard matrix block. It converts ps2_key events into a ROWSxCOLS pressed-key matrix through an external scancode lookup port. A FIFO-fed timed keystroke injector ("autotype") presses and releases matrix positions on its own. The CPU-facing side returns active-low row sense lines for the active-low column strobe pattern written to the PIA, exactly as the current keyboard path does.

---
 rtl/coco_kbd_matrix.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_coco_kbd_matrix.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coco_kbd_matrix.sv
// coco_kbd_matrix
// Keyboard matrix for a CoCo-style PIA scan. PS/2 events are mapped to a
// ROWS x COLS pressed-key plane through an external lookup port. A FIFO-fed
// injector presses and releases matrix positions on its own with a fixed
// hold/gap cadence. The PIA side sees active-low row sense lines for the
// active-low column strobe, combinationally.

module coco_kbd_matrix #(
    parameter int ROWS        = 7,
    parameter int COLS        = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int HOLD_CYCLES = 60000,
    parameter int GAP_CYCLES  = 60000,
    parameter int SHIFT_ROW   = 6,
    parameter int SHIFT_COL   = 7,
    localparam int ROW_W      = $clog2(ROWS),
    localparam int COL_W      = $clog2(COLS),
    localparam int POS_W      = ROW_W + COL_W
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [10:0]      ps2_key,
    output logic [8:0]       map_code,
    input  logic             map_hit,
    input  logic [POS_W-1:0] map_pos,
    input  logic [COLS-1:0]  col_strobe,
    output logic [ROWS-1:0]  kb_rows,
    input  logic             inj_valid,
    output logic             inj_ready,
    input  logic [POS_W-1:0] inj_pos,
    input  logic             inj_shift,
    input  logic             kb_clear,
    output logic             inj_busy,
    output logic [11:1]      Fn,
    output logic [2:0]       modif
);

    // Counter sized for the longer of the two phases
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    // FIFO geometry: pointers wrap naturally because depth is a power of two
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FIFO_FULL = FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } inj_state_t;

    // ------------------------------------------------------------------
    // PS/2 event capture
    // ------------------------------------------------------------------
    logic       toggle_prev_reg;
    logic [8:0] code_reg;
    logic       press_reg;
    logic       evt_pending_reg;
    logic       evt_detect;

    assign evt_detect = ps2_key[10] ^ toggle_prev_reg;

    // Edge detector on the toggle bit; reset tracks the current level so a
    // stale toggle never looks like a fresh event
    always_ff @(posedge clk_sys) begin
        toggle_prev_reg <= ps2_key[10];
    end

    // Latch the event payload one cycle after the toggle edge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            code_reg        <= '0;
            press_reg       <= 1'b0;
            evt_pending_reg <= 1'b0;
        end else begin
            evt_pending_reg <= evt_detect;
            if (evt_detect) begin
                code_reg  <= {ps2_key[8], ps2_key[7:0]};
                press_reg <= ps2_key[9];
            end
        end
    end

    assign map_code = code_reg;

    // ------------------------------------------------------------------
    // Physical key plane
    // ------------------------------------------------------------------
    logic [ROWS-1:0][COLS-1:0] phys_reg;
    logic [ROW_W-1:0]          map_row;
    logic [COL_W-1:0]          map_col;
    logic                      map_in_range;

    assign map_row      = map_pos[POS_W-1:COL_W];
    assign map_col      = map_pos[COL_W-1:0];
    assign map_in_range = (int'(map_row) < ROWS) && (int'(map_col) < COLS);

    // Apply the looked-up press/release; a clear pulse overrides any update
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            phys_reg <= '0;
        end else if (kb_clear) begin
            phys_reg <= '0;
        end else if (evt_pending_reg && map_hit && map_in_range) begin
            phys_reg[map_row][map_col] <= press_reg;
        end
    end

    // ------------------------------------------------------------------
    // Function keys and modifiers, decoded straight from the scancode
    // ------------------------------------------------------------------
    logic [11:1] fn_reg;
    logic [2:0]  modif_reg;

    // Track held state of F1..F11 and ctrl/alt/right-shift; extended bit ignored
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fn_reg    <= '0;
            modif_reg <= '0;
        end else if (evt_pending_reg) begin
            case (code_reg[7:0])
                8'h05:   fn_reg[1]    <= press_reg;
                8'h06:   fn_reg[2]    <= press_reg;
                8'h04:   fn_reg[3]    <= press_reg;
                8'h0C:   fn_reg[4]    <= press_reg;
                8'h03:   fn_reg[5]    <= press_reg;
                8'h0B:   fn_reg[6]    <= press_reg;
                8'h83:   fn_reg[7]    <= press_reg;
                8'h0A:   fn_reg[8]    <= press_reg;
                8'h01:   fn_reg[9]    <= press_reg;
                8'h09:   fn_reg[10]   <= press_reg;
                8'h78:   fn_reg[11]   <= press_reg;
                8'h59:   modif_reg[0] <= press_reg;
                8'h11:   modif_reg[1] <= press_reg;
                8'h14:   modif_reg[2] <= press_reg;
                default: ;
            endcase
        end
    end

    assign Fn    = fn_reg;
    assign modif = modif_reg;

    // ------------------------------------------------------------------
    // Injection FIFO
    // ------------------------------------------------------------------
    logic [POS_W:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   rd_addr;
    logic [FW-1:0]   count_reg;
    logic [FW-1:0]   count_next;
    logic            ready_reg;
    logic [POS_W:0]  rd_data_reg;
    logic [POS_W:0]  wr_data;
    logic            push;
    logic            pop;

    assign push    = inj_valid && ready_reg;
    assign wr_data = {inj_shift, inj_pos};
    assign rd_addr = pop ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;

    // Occupancy bookkeeping; a push and pop together leave the count alone
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + FW'(1);
            2'b01:   count_next = count_reg - FW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage array, written on accepted pushes
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Registered head-of-queue read; bypass covers a write to the head slot
    always_ff @(posedge clk_sys) begin
        if (push && (wr_ptr_reg == rd_addr)) begin
            rd_data_reg <= wr_data;
        end else begin
            rd_data_reg <= fifo_mem[rd_addr];
        end
    end

    // Pointers, count and the registered ready flag
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            ready_reg <= (count_next != FIFO_FULL);
        end
    end

    assign inj_ready = ready_reg;

    // ------------------------------------------------------------------
    // Injector FSM and injected key plane
    // ------------------------------------------------------------------
    inj_state_t                state_reg;
    inj_state_t                state_next;
    logic [CNT_W-1:0]          cnt_reg;
    logic [CNT_W-1:0]          cnt_next;
    logic [ROWS-1:0][COLS-1:0] inj_reg;
    logic [ROWS-1:0][COLS-1:0] inj_next;
    logic [ROW_W-1:0]          head_row;
    logic [COL_W-1:0]          head_col;
    logic                      head_shift;
    logic                      head_in_range;

    assign head_shift    = rd_data_reg[POS_W];
    assign head_row      = rd_data_reg[POS_W-1:COL_W];
    assign head_col      = rd_data_reg[COL_W-1:0];
    assign head_in_range = (int'(head_row) < ROWS) && (int'(head_col) < COLS);

    // State, counter and injected-plane registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            inj_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            inj_reg   <= inj_next;
        end
    end

    // Next state: pop and press in IDLE, hold for HOLD, release and wait GAP
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        inj_next   = inj_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    pop = 1'b1;
                    // An out-of-range entry is consumed without pressing anything
                    if (head_in_range) begin
                        inj_next[head_row][head_col] = 1'b1;
                        if (head_shift) begin
                            inj_next[SHIFT_ROW][SHIFT_COL] = 1'b1;
                        end
                    end
                    cnt_next   = HOLD_LOAD;
                    state_next = PRESS;
                end
            end
            PRESS: begin
                if (cnt_reg == '0) begin
                    inj_next   = '0;
                    cnt_next   = GAP_LOAD;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                inj_next   = '0;
            end
        endcase
    end

    assign inj_busy = (state_reg != IDLE) || (count_reg != '0);

    // ------------------------------------------------------------------
    // PIA scan: a row reads low when any selected column has a pressed key
    // ------------------------------------------------------------------
    logic [ROWS-1:0][COLS-1:0] pressed;

    assign pressed = phys_reg | inj_reg;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign kb_rows[gi] = ~|(pressed[gi] & ~col_strobe);
    end

endmodule

// File: tb/tb_coco_kbd_matrix.sv
// Directed testbench for coco_kbd_matrix with short hold/gap timing.

module tb_coco_kbd_matrix;

    localparam int POS_W = 6;

    logic             clk;
    logic             reset;
    logic [10:0]      ps2_key;
    logic [8:0]       map_code;
    logic             map_hit;
    logic [POS_W-1:0] map_pos;
    logic [7:0]       col_strobe;
    logic [6:0]       kb_rows;
    logic             inj_valid;
    logic             inj_ready;
    logic [POS_W-1:0] inj_pos;
    logic             inj_shift;
    logic             kb_clear;
    logic             inj_busy;
    logic [11:1]      Fn;
    logic [2:0]       modif;

    int   checks;
    int   failures;
    logic tog;
    int   accepted;
    int   waited;

    logic mon_en;
    logic mon_prev;
    int   mon_keys;

    coco_kbd_matrix #(
        .ROWS(7),
        .COLS(8),
        .FIFO_DEPTH(16),
        .HOLD_CYCLES(4),
        .GAP_CYCLES(3),
        .SHIFT_ROW(6),
        .SHIFT_COL(7)
    ) dut (
        .clk_sys(clk),
        .reset(reset),
        .ps2_key(ps2_key),
        .map_code(map_code),
        .map_hit(map_hit),
        .map_pos(map_pos),
        .col_strobe(col_strobe),
        .kb_rows(kb_rows),
        .inj_valid(inj_valid),
        .inj_ready(inj_ready),
        .inj_pos(inj_pos),
        .inj_shift(inj_shift),
        .kb_clear(kb_clear),
        .inj_busy(inj_busy),
        .Fn(Fn),
        .modif(modif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External scancode lookup table
    always_comb begin
        map_hit = 1'b0;
        map_pos = '0;
        case (map_code)
            9'h01C: begin map_hit = 1'b1; map_pos = {3'd0, 3'd1}; end
            9'h02C: begin map_hit = 1'b1; map_pos = {3'd2, 3'd3}; end
            9'h033: begin map_hit = 1'b1; map_pos = {3'd7, 3'd0}; end
            default: ;
        endcase
    end

    // Counts injected keystrokes on row 2 (falling edges of the sense line)
    always @(negedge clk) begin
        if (!mon_en) begin
            mon_keys = 0;
            mon_prev = 1'b0;
        end else begin
            if (!kb_rows[2] && !mon_prev) mon_keys = mon_keys + 1;
            mon_prev = !kb_rows[2];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic ext, input logic prs, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, prs, ext, code};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (inj_busy && n < 500) begin
            step(1);
            n = n + 1;
        end
        chk("idle_wait", {31'd0, inj_busy}, 32'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        tog        = 1'b0;
        reset      = 1'b1;
        ps2_key    = '0;
        col_strobe = 8'hFF;
        inj_valid  = 1'b0;
        inj_pos    = '0;
        inj_shift  = 1'b0;
        kb_clear   = 1'b0;
        mon_en     = 1'b0;
        accepted   = 0;
        waited     = 0;

        // Reset state
        step(3);
        chk("rst_rows", 32'(kb_rows), 32'h7F);
        chk("rst_ready", 32'(inj_ready), 32'd1);
        chk("rst_busy", 32'(inj_busy), 32'd0);
        chk("rst_fn", 32'(Fn), 32'd0);
        chk("rst_modif", 32'(modif), 32'd0);
        chk("rst_map_code", 32'(map_code), 32'd0);
        reset = 1'b0;
        step(1);

        // Physical press/release through the lookup
        col_strobe = 8'hFD;
        send(1'b0, 1'b1, 8'h1C);
        step(1);
        chk("ev_map_code", 32'(map_code), 32'h01C);
        chk("ev_rows_t1", 32'(kb_rows), 32'h7F);
        step(1);
        chk("ev_rows_press", 32'(kb_rows), 32'h7E);
        col_strobe = 8'hFF;
        #1;
        chk("ev_rows_unsel", 32'(kb_rows), 32'h7F);
        col_strobe = 8'hFD;
        send(1'b0, 1'b0, 8'h1C);
        step(2);
        chk("ev_rows_release", 32'(kb_rows), 32'h7F);

        // Function keys and modifiers
        send(1'b0, 1'b1, 8'h05);
        step(2);
        chk("fn1_press", 32'(Fn), 32'h001);
        send(1'b0, 1'b0, 8'h05);
        step(2);
        chk("fn1_release", 32'(Fn), 32'h000);
        send(1'b0, 1'b1, 8'h83);
        step(2);
        chk("fn7_press", 32'(Fn), 32'h040);
        send(1'b0, 1'b0, 8'h83);
        step(2);
        send(1'b1, 1'b1, 8'h14);
        step(2);
        chk("modif_ctrl_ext", 32'(modif), 32'h4);
        send(1'b0, 1'b1, 8'h59);
        step(2);
        chk("modif_rshift", 32'(modif), 32'h5);
        send(1'b1, 1'b0, 8'h14);
        step(2);
        send(1'b0, 1'b0, 8'h59);
        step(2);
        chk("modif_release", 32'(modif), 32'h0);
        chk("fn_after", 32'(Fn), 32'h000);

        // Out-of-range lookup position is ignored
        col_strobe = 8'h00;
        send(1'b0, 1'b1, 8'h33);
        step(2);
        chk("oor_rows", 32'(kb_rows), 32'h7F);
        send(1'b0, 1'b0, 8'h33);
        step(2);

        // Two injected keys: shifted then plain, 8-cycle period
        col_strobe = 8'hF7;
        wait_idle();
        inj_valid = 1'b1;
        inj_pos   = {3'd2, 3'd3};
        inj_shift = 1'b1;
        step(1);
        chk("inj_busy_c1", 32'(inj_busy), 32'd1);
        chk("inj_rows_c1", 32'(kb_rows), 32'h7F);
        inj_shift = 1'b0;
        step(1);
        inj_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            col_strobe = 8'hF7;
            #1;
            chk($sformatf("inj_key_c%0d", i + 2), 32'(kb_rows),
                ((i < 4) || (i >= 8)) ? 32'h7B : 32'h7F);
            col_strobe = 8'h7F;
            #1;
            chk($sformatf("inj_shift_c%0d", i + 2), 32'(kb_rows),
                (i < 4) ? 32'h3F : 32'h7F);
            col_strobe = 8'hF7;
            step(1);
        end
        step(2);
        chk("inj_busy_gap", 32'(inj_busy), 32'd1);
        step(1);
        chk("inj_busy_done", 32'(inj_busy), 32'd0);

        // Physical and injected press of the same key coexist
        wait_idle();
        send(1'b0, 1'b1, 8'h2C);
        step(2);
        chk("both_phys", 32'(kb_rows), 32'h7B);
        inj_valid = 1'b1;
        inj_pos   = {3'd2, 3'd3};
        inj_shift = 1'b0;
        step(1);
        inj_valid = 1'b0;
        step(1);
        send(1'b0, 1'b0, 8'h2C);
        step(2);
        chk("both_phys_rel_a", 32'(kb_rows), 32'h7B);
        step(1);
        chk("both_phys_rel_b", 32'(kb_rows), 32'h7B);
        step(1);
        chk("both_press_end", 32'(kb_rows), 32'h7F);

        // kb_clear releases only the physical plane
        wait_idle();
        send(1'b0, 1'b1, 8'h2C);
        step(2);
        inj_valid = 1'b1;
        step(1);
        inj_valid = 1'b0;
        step(1);
        kb_clear = 1'b1;
        step(1);
        kb_clear = 1'b0;
        chk("clr_inj_held", 32'(kb_rows), 32'h7B);
        chk("clr_busy", 32'(inj_busy), 32'd1);
        step(3);
        chk("clr_phys_gone", 32'(kb_rows), 32'h7F);

        // FIFO fill while the injector drains at one key per 8 cycles
        wait_idle();
        mon_en    = 1'b1;
        inj_pos   = {3'd2, 3'd3};
        inj_shift = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 20; i++) begin
            inj_valid = 1'b1;
            if (inj_ready) accepted = accepted + 1;
            step(1);
            if (i == 17) chk("fill_ready_hi", 32'(inj_ready), 32'd1);
            if (i == 18) chk("fill_ready_lo", 32'(inj_ready), 32'd0);
        end
        inj_valid = 1'b0;
        chk("fill_accepted", 32'(accepted), 32'd19);
        waited = 0;
        while (inj_busy && waited < 400) begin
            step(1);
            waited = waited + 1;
        end
        chk("fill_drain_cycles", 32'(waited), 32'd133);
        chk("fill_keys", 32'(mon_keys), 32'd19);
        mon_en = 1'b0;

        // Reset in the middle of a keystroke with entries queued
        send(1'b0, 1'b1, 8'h05);
        step(2);
        chk("pre_rst_fn", 32'(Fn), 32'h001);
        col_strobe = 8'hF7;
        for (int i = 0; i < 4; i++) begin
            inj_valid = 1'b1;
            step(1);
        end
        inj_valid = 1'b0;
        chk("mid_press_rows", 32'(kb_rows), 32'h7B);
        chk("mid_press_busy", 32'(inj_busy), 32'd1);
        reset   = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
        tog     = 1'b1;
        step(1);
        chk("mrst_rows", 32'(kb_rows), 32'h7F);
        chk("mrst_busy", 32'(inj_busy), 32'd0);
        chk("mrst_ready", 32'(inj_ready), 32'd1);
        chk("mrst_fn", 32'(Fn), 32'd0);
        reset      = 1'b0;
        col_strobe = 8'hFD;
        step(3);
        chk("post_rst_no_event_rows", 32'(kb_rows), 32'h7F);
        chk("post_rst_map_code", 32'(map_code), 32'd0);
        chk("post_rst_busy", 32'(inj_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
